tatzel_freq_counter: RTL and testbench
======================================

// Module: tatzel_freq_counter
// PURPOSE
//  Gated edge counter feeding the tt_um_tatzeltapeout top: it measures the frequency of an
//  asynchronous oscillator/comparator signal arriving on a digital input pin. Count = rising
//  edges within a programmable window of clk cycles; read back byte-wise on uo_out.
// PARAMETERS
//  CNT_W        16  edge-count width; count saturates at 2**CNT_W-1
//  GATE_W       16  gate-length width, in clk cycles
//  SYNC_STAGES   2  flops in the sig_in synchronizer (>=2)
// PORTS
//  clk       in   1       system clock
//  rst_n     in   1       asynchronous active-low reset
//  ena       in   1       design enable; low aborts to IDLE
//  sig_in    in   1       asynchronous signal under measurement
//  start     in   1       level-sampled request; acted on only in IDLE
//  gate_len  in   GATE_W  window length N; sampled in ARM
//  busy      out  1       high in ARM and MEASURE
//  done      out  1       one-cycle pulse; count/overflow valid from this cycle
//  count     out  CNT_W   last result; held until next ARM
//  overflow  out  1       set if count saturated during the last window
//  byte_sel  in   2       selects count byte for dout (0 = LSB)
//  dout      out  8       count[8*byte_sel +: 8], zero beyond CNT_W; combinational
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, count=0, overflow=0, synchronizer and edge flop =0.
//  Input path: SYNC_STAGES flops, then one edge flop; edge_p = sync & ~sync_d.
//  FSM states IDLE, ARM, MEASURE, DONE:
//   IDLE->ARM when start=1 (start at edge t => ARM at t+1).
//   ARM: clear count/overflow, load gate counter with gate_len; N=0 -> DONE, else -> MEASURE.
//   MEASURE lasts exactly N cycles (t+2..t+1+N); count increments on each cycle with edge_p=1.
//   DONE (t+2+N, or t+2 when N=0): done=1 for this one cycle; -> IDLE.
//  Saturation: an increment at 2**CNT_W-1 holds the value and sets overflow (sticky to ARM).
//  start in ARM/MEASURE/DONE is ignored; no queuing. A start held high re-arms from IDLE.
//  ena=0 in any state: next state IDLE, done not pulsed, count/overflow keep current value.
//  rst_n low mid-window: everything returns to reset values immediately (async).
//  gate_len changes after ARM have no effect on the running window.
// CONFIGURATION
//  FREQCNT_CONTINUOUS_EN defined: DONE -> ARM directly (back-to-back windows, no IDLE cycle)
//   while ena=1; start is needed only for the first window; deassert by driving ena=0.
//  Not defined: DONE -> IDLE always, as above.
// STRUCTURE
//  Package tatzel_freqcnt_pkg: state enum (IDLE, ARM, MEASURE, DONE), default widths,
//   localparam CNT_MAX function.
//  Sub-module tatzel_sync_edge: SYNC_STAGES synchronizer plus rising-edge pulse; reused for
//   any other asynchronous pin the top adds later. Counter, FSM and dout mux live here.
// TESTING
//  1. sig_in clk-aligned period 8 (4 high/4 low), gate_len=80, start pulse -> done at t+82,
//     count=10, overflow=0, busy high t+1..t+81.
//  2. CNT_W=4, sig_in period 2, gate_len=40 -> count=15, overflow=1; next window with no
//     activity -> count=0, overflow=0.
//  3. gate_len=0 -> done at t+2, count=0; busy high only at t+1.
//  4. ena dropped mid-MEASURE -> IDLE next cycle, no done, count holds partial value;
//     rst_n pulse mid-window -> all outputs 0 asynchronously.
//  5. count=0x1234 -> dout: byte_sel=0 ->0x34, 1 ->0x12, 2 ->0x00, 3 ->0x00.
//  6. FREQCNT_CONTINUOUS_EN, gate_len=10, single start -> done every 12 cycles until ena=0.

Source files
------------

// File: rtl/tatzel_freqcnt_pkg.sv
// Shared types and defaults for the tatzel frequency counter.
package tatzel_freqcnt_pkg;

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_GATE_W      = 16;
    localparam int DEF_SYNC_STAGES = 2;

    function automatic logic [63:0] cnt_max(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/tatzel_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin followed by a rising-edge detector.
module tatzel_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic edge_p
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            sync_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            sync_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_p = sync_q[SYNC_STAGES-1] & ~sync_d;

endmodule

// File: rtl/tatzel_freq_counter.sv
// Gated rising-edge counter with byte-wise readback.
// Define FREQCNT_CONTINUOUS_EN for back-to-back windows without an IDLE cycle.
module tatzel_freq_counter
    import tatzel_freqcnt_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GATE_W      = DEF_GATE_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              sig_in,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    input  logic [1:0]        byte_sel,
    output logic [7:0]        dout
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(cnt_max(CNT_W));
    localparam int               PAD_W   = (CNT_W > 32) ? CNT_W : 32;

    state_t             state, state_nxt;
    logic [GATE_W-1:0]  gate_cnt;
    logic               edge_p;
    logic [PAD_W-1:0]   cnt_ext;

    tatzel_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (sig_in),
        .edge_p (edge_p)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ARM;
            ARM:     state_nxt = (gate_len == '0) ? DONE : MEASURE;
            MEASURE: if (gate_cnt == GATE_W'(1)) state_nxt = DONE;
`ifdef FREQCNT_CONTINUOUS_EN
            DONE:    state_nxt = ARM;
`else
            DONE:    state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
        if (!ena) state_nxt = IDLE;
    end

    // Data registers only move while enabled so an abort leaves the partial result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gate_cnt <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ena) begin
                case (state)
                    ARM: begin
                        count    <= '0;
                        overflow <= 1'b0;
                        gate_cnt <= gate_len;
                    end
                    MEASURE: begin
                        gate_cnt <= gate_cnt - GATE_W'(1);
                        if (edge_p) begin
                            if (count == CNT_SAT) overflow <= 1'b1;
                            else                  count    <= count + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy    = (state == ARM) || (state == MEASURE);
    assign done    = (state == DONE) && ena;
    assign cnt_ext = PAD_W'(count);
    assign dout    = cnt_ext[{byte_sel, 3'b000} +: 8];

endmodule

// File: tb/tb_tatzel_freq_counter.sv
// Self-checking bench: window-level reference model plus directed literal checks.
module tb_tatzel_freq_counter;

    localparam int S = 2;

    logic        clk = 1'b0, rst_n = 1'b0, ena = 1'b0, sig_in = 1'b0, start = 1'b0;
    logic [15:0] gate_len = '0;
    logic [1:0]  byte_sel = '0;

    logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [15:0] count_a;
    logic [3:0]  count_b;
    logic [7:0]  dout_a, dout_b;

    int n_checks = 0, n_err = 0;
    int m_cyc = 0;
    int sig_mode = 0;

    tatzel_freq_counter dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sig_in(sig_in), .start(start),
        .gate_len(gate_len), .busy(busy_a), .done(done_a), .count(count_a),
        .overflow(ovf_a), .byte_sel(byte_sel), .dout(dout_a)
    );

    tatzel_freq_counter #(.CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sig_in(sig_in), .start(start),
        .gate_len(gate_len), .busy(busy_b), .done(done_b), .count(count_b),
        .overflow(ovf_b), .byte_sel(byte_sel), .dout(dout_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, m_cyc);
        end
    endtask

    // Reference model: a window is described by its ARM cycle ws and length nw;
    // the raw (unsaturated) number of synchronized rising edges seen inside it is kept in raw.
    bit [S:0]    h;
    int unsigned raw;
    bit          active;
    int          ws, nw;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h = '0; raw = 0; active = 0; ws = 0; nw = 0;
        end else begin
            int o;
            bit ep;
            o  = m_cyc - ws;
            ep = h[S-1] & ~h[S];
            m_cyc++;
            if (!ena) active = 0;
            else if (!active) begin
                if (start) begin active = 1; ws = m_cyc; end
            end else begin
                if (o == 0) begin raw = 0; nw = int'(gate_len); end
                else if (o <= nw) raw += ep;
                if (o == nw + 1) begin
`ifdef FREQCNT_CONTINUOUS_EN
                    ws = m_cyc;
`else
                    active = 0;
`endif
                end
            end
            h = {h[S-1:0], sig_in};
        end
    end

    always @(negedge clk) begin : cmp
        int          o2;
        bit          e_busy, e_done;
        int unsigned ea, eb;
        logic [31:0] xa, xb;
        o2     = m_cyc - ws;
        e_busy = active && (o2 == 0 || o2 <= nw);
        e_done = active && o2 >= 1 && o2 == nw + 1 && ena;
        ea     = (raw > 65535) ? 65535 : raw;
        eb     = (raw > 15) ? 15 : raw;
        xa     = ea;
        xb     = eb;
        check("busy",       busy_a,  e_busy);
        check("done",       done_a,  e_done);
        check("count",      count_a, ea);
        check("overflow",   ovf_a,   raw > 65535);
        check("dout",       dout_a,  xa[byte_sel*8 +: 8]);
        check("count4",     count_b, eb);
        check("overflow4",  ovf_b,   raw > 15);
        check("dout4",      dout_b,  xb[byte_sel*8 +: 8]);
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (sig_mode)
            0: sig_in = 1'b0;
            1: sig_in = (m_cyc % 8) < 4;
            2: sig_in = ~sig_in;
            default: sig_in = 1'($urandom % 2);
        endcase
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Raise start during cycle t and follow the window until done (latency from t).
    task automatic run_window(input int n, input int limit, output int dlat, output int bcnt);
        int t;
        bit got;
        gate_len = 16'(n);
        start    = 1'b1;
        t        = m_cyc;
        tick;
        start = 1'b0;
        bcnt  = 0;
        dlat  = -1;
        got   = 0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            if (busy_a) bcnt++;
            if (done_a) begin got = 1; dlat = m_cyc - t; end
        end
        check("window_reached_done", got, 1);
        #1 ena = 1'b0;
        tick;
        ena = 1'b1;
    endtask

    initial begin
        int dl, bc, v;
        bit seen;

        repeat (3) tick;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_count", count_a, 0);
        check("rst_ovf", ovf_a, 0);
        rst_n = 1'b1;
        ena   = 1'b1;
        repeat (2) tick;

        sig_mode = 1;
        repeat (4) tick;
        run_window(80, 200, dl, bc);
        check("t1_done_lat", dl, 82);
        check("t1_busy_cycles", bc, 81);
        check("t1_count", count_a, 10);
        check("t1_ovf", ovf_a, 0);

        sig_mode = 2;
        repeat (4) tick;
        run_window(40, 100, dl, bc);
        check("t2_count4", count_b, 15);
        check("t2_ovf4", ovf_b, 1);
        check("t2_count16", count_a, 20);
        sig_mode = 0;
        repeat (5) tick;
        run_window(40, 100, dl, bc);
        check("t2b_count4", count_b, 0);
        check("t2b_ovf4", ovf_b, 0);

        run_window(0, 20, dl, bc);
        check("t3_done_lat", dl, 2);
        check("t3_busy_cycles", bc, 1);
        check("t3_count", count_a, 0);

        sig_mode = 1;
        gate_len = 16'd100;
        start    = 1'b1;
        tick;
        start = 1'b0;
        repeat (40) tick;
        ena = 1'b0;
        tick;
        check("t4_abort_busy", busy_a, 0);
        v = int'(count_a);
        check("t4_partial_nonzero", v != 0, 1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_a) seen = 1;
        end
        check("t4_no_done", seen, 0);
        check("t4_count_held", count_a, v);
        #1 ena = 1'b1;
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (30) tick;
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_busy", busy_a, 0);
        check("t4_rst_count", count_a, 0);
        check("t4_rst_ovf", ovf_a, 0);
        check("t4_rst_done", done_a, 0);
        #3 rst_n = 1'b1;
        repeat (4) tick;

        sig_mode = 2;
        repeat (4) tick;
        run_window(9320, 9400, dl, bc);
        check("t5_count", count_a, 16'h1234);
        for (int b = 0; b < 4; b++) begin
            logic [7:0] exp_b [4];
            exp_b[0] = 8'h34; exp_b[1] = 8'h12; exp_b[2] = 8'h00; exp_b[3] = 8'h00;
            byte_sel = 2'(b);
            #1;
            check("t5_dout", dout_a, exp_b[b]);
        end
        byte_sel = 2'd0;
        tick;

`ifdef FREQCNT_CONTINUOUS_EN
        begin
            int last, cnt_done;
            sig_mode = 3;
            gate_len = 16'd10;
            start    = 1'b1;
            tick;
            start    = 1'b0;
            last     = -1;
            cnt_done = 0;
            for (int i = 0; i < 100 && cnt_done < 4; i++) begin
                @(negedge clk);
                if (done_a) begin
                    if (last >= 0) check("t6_done_period", m_cyc - last, 12);
                    last = m_cyc;
                    cnt_done++;
                end
            end
            check("t6_done_seen", cnt_done, 4);
            #1 ena = 1'b0;
            tick;
            check("t6_stop_busy", busy_a, 0);
            ena = 1'b1;
            seen = 0;
            repeat (20) begin
                @(negedge clk);
                if (done_a) seen = 1;
            end
            check("t6_stopped", seen, 0);
            tick;
        end
`endif

        sig_mode = 3;
        repeat (3000) begin
            ena      = ($urandom % 40) != 0;
            start    = ($urandom % 6) == 0;
            gate_len = 16'($urandom % 80);
            byte_sel = 2'($urandom % 4);
            tick;
        end
        ena   = 1'b1;
        start = 1'b0;
        repeat (5) tick;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
